// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The optional MEM_ARB_RR_EN build switch is consumed by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } mem_arb_state_t;

  localparam int MEM_ARB_DEPTH = 32;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and load/store ports.
// MEM_ARB_RR_EN: round-robin on ties; otherwise the fetch port always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef MEM_ARB_RR_EN
  input  logic last,
`endif
  output logic any,
  output logic win
);

  always_comb begin
    any = req0 | req1;
    win = PORT_IFETCH;
    if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
      // last holds the index of the previous winner, so the other port goes next
      win = ~last;
`else
      win = PORT_IFETCH;
`endif
    end else if (req1) begin
      win = PORT_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter driving a level-sensitive memory with a setup/strobe/release cycle.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = MEM_ARB_DEPTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              GNT0,
  output logic              DONE0,
  output logic              ERR0,
  output logic [DATA_W-1:0] RDATA0,
  input  logic              REQ1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT1,
  output logic              DONE1,
  output logic              ERR1,
  output logic [DATA_W-1:0] RDATA1,
  output logic              MEM_WRITE,
  output logic              MEM_READ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  mem_arb_state_t    state;
  logic              port;
  logic              we_l;
  logic              skip;
  logic              any;
  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

`ifdef MEM_ARB_RR_EN
  logic              last;
`endif

  mem_arb_pick u_pick (
    .req0 (REQ0),
    .req1 (REQ1),
`ifdef MEM_ARB_RR_EN
    .last (last),
`endif
    .any  (any),
    .win  (win)
  );

  always_comb begin
    sel_addr  = (win == PORT_LSU) ? ADDR1  : ADDR0;
    sel_wdata = (win == PORT_LSU) ? WDATA1 : WDATA0;
    sel_we    = (win == PORT_LSU) ? WE1    : WE0;
  end

  // MEM_ADDR / MEM_WDATA double as the latched payload: they only move on entry to SETUP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      port      <= PORT_IFETCH;
      we_l      <= 1'b0;
      skip      <= 1'b0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      ERR0      <= 1'b0;
      ERR1      <= 1'b0;
      RDATA0    <= '0;
      RDATA1    <= '0;
      MEM_WRITE <= 1'b0;
      MEM_READ  <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
`ifdef MEM_ARB_RR_EN
      last      <= PORT_LSU;
`endif
    end else begin
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      ERR0      <= 1'b0;
      ERR1      <= 1'b0;
      MEM_WRITE <= 1'b0;
      MEM_READ  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            port      <= win;
            we_l      <= sel_we;
            MEM_ADDR  <= sel_addr;
            MEM_WDATA <= sel_wdata;
            skip      <= (sel_addr >= ADDR_W'(DEPTH));
            GNT0      <= (win == PORT_IFETCH);
            GNT1      <= (win == PORT_LSU);
`ifdef MEM_ARB_RR_EN
            last      <= win;
`endif
            state     <= SETUP;
          end
        end
        SETUP: begin
          MEM_WRITE <= we_l & ~skip;
          MEM_READ  <= ~we_l & ~skip;
          state     <= STROBE;
        end
        STROBE: begin
          if (!we_l) begin
            if (port == PORT_LSU) begin
              RDATA1 <= skip ? '0 : MEM_RDATA;
            end else begin
              RDATA0 <= skip ? '0 : MEM_RDATA;
            end
          end
          DONE0 <= (port == PORT_IFETCH);
          DONE1 <= (port == PORT_LSU);
          ERR0  <= (port == PORT_IFETCH) & skip;
          ERR1  <= (port == PORT_LSU) & skip;
          state <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
